// File: rtl/clk_div_gen_if.sv
// Configuration bus of clk_div_gen: write strobe, channel, ratio, enable and error pulse.
interface clk_div_gen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_wr,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel divided-clock / tick generator with boundary-aligned reconfiguration.
// Optional CLK_DIV_GEN_SYNC_EN adds sync_i to phase-align all running channels.
module clk_div_gen #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CLK_DIV_GEN_SYNC_EN
    input  logic              sync_i,
`endif
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] div_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] run_o,
    output logic [NUM_CH-1:0] pend_o
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {StIdle, StRun} st_e;

    logic sync;
    logic ch_legal;
    logic wr_en;
    logic cfg_err_q;

`ifdef CLK_DIV_GEN_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // With a power-of-two channel count every index is legal.
    if (NUM_CH == (1 << CH_W)) begin : g_full
        assign ch_legal = 1'b1;
    end else begin : g_part
        assign ch_legal = (cfg.cfg_ch < CH_W'(NUM_CH));
    end

    assign wr_en = cfg.cfg_en & (cfg.cfg_div != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg.cfg_wr & ~ch_legal;
        end
    end

    assign cfg.cfg_err = cfg_err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        st_e              st_q, st_d;
        logic [DIV_W-1:0] n_q, n_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] pn_q, pn_d;
        logic             pen_q, pen_d;
        logic             pv_q, pv_d;
        logic             div_q, div_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             boundary;
        logic [DIV_W:0]   hi_lim;

        assign wr_hit   = cfg.cfg_wr & ch_legal & (cfg.cfg_ch == CH_W'(gi));
        assign boundary = (st_q == StRun) & ((cnt_q == n_q - DIV_W'(1)) | sync);

        always_comb begin
            st_d   = st_q;
            n_d    = n_q;
            cnt_d  = cnt_q;
            pn_d   = pn_q;
            pen_d  = pen_q;
            pv_d   = pv_q;
            hi_lim = '0;
            if (st_q == StIdle) begin
                if (wr_hit && wr_en) begin
                    st_d  = StRun;
                    n_d   = cfg.cfg_div;
                    cnt_d = '0;
                end
            end else begin
                if (boundary) begin
                    cnt_d = '0;
                    if (pv_q) begin
                        pv_d = 1'b0;
                        if (pen_q) begin
                            n_d = pn_q;
                        end else begin
                            st_d = StIdle;
                            n_d  = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                // A write on the boundary edge waits for the following boundary.
                if (wr_hit) begin
                    pn_d  = cfg.cfg_div;
                    pen_d = wr_en;
                    pv_d  = 1'b1;
                end
            end
            hi_lim = ({1'b0, n_d} + (DIV_W + 1)'(1)) >> 1;
            div_d  = (st_d == StRun) && ({1'b0, cnt_d} < hi_lim);
            tick_d = (st_d == StRun) && (cnt_d == '0);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= StIdle;
                n_q    <= '0;
                cnt_q  <= '0;
                pn_q   <= '0;
                pen_q  <= 1'b0;
                pv_q   <= 1'b0;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                n_q    <= n_d;
                cnt_q  <= cnt_d;
                pn_q   <= pn_d;
                pen_q  <= pen_d;
                pv_q   <= pv_d;
                div_q  <= div_d;
                tick_q <= tick_d;
            end
        end

        assign div_o[gi]  = div_q;
        assign tick_o[gi] = tick_q;
        assign run_o[gi]  = (st_q == StRun);
        assign pend_o[gi] = pv_q;
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a per-cycle period model predicts every output cycle.
module tb_clk_div_gen;
    localparam int NC = 6;
    localparam int DW = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [NC-1:0] dv;
        logic [NC-1:0] tk;
        logic [NC-1:0] rn;
        logic [NC-1:0] pd;
        logic          er;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          sync;
    logic [NC-1:0] div_o, tick_o, run_o, pend_o;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    exp_t exp_q[$];

    // Model: where each channel is inside its current period.
    bit m_run[NC];
    int m_n[NC];
    int m_pos[NC];
    bit m_pv[NC];
    int m_pn[NC];
    bit m_pen[NC];

    clk_div_gen_if #(.NUM_CH(NC), .DIV_W(DW)) cfg_if ();

    clk_div_gen #(.NUM_CH(NC), .DIV_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef CLK_DIV_GEN_SYNC_EN
        .sync_i (sync),
`endif
        .cfg    (cfg_if.slave),
        .div_o  (div_o),
        .tick_o (tick_o),
        .run_o  (run_o),
        .pend_o (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_no, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_run[i] = 0; m_n[i] = 0; m_pos[i] = 0;
            m_pv[i] = 0;  m_pn[i] = 0; m_pen[i] = 0;
        end
    endtask

    task automatic model_step(input bit wr, input int ch, input int dv, input bit en,
                              input bit sy, output exp_t e);
        bit en_eff;
        en_eff = en && (dv != 0);
        e = '0;
        for (int i = 0; i < NC; i++) begin
            if (m_run[i]) begin
                if ((m_pos[i] == m_n[i] - 1) || sy) begin
                    m_pos[i] = 0;
                    if (m_pv[i]) begin
                        m_pv[i] = 0;
                        if (m_pen[i]) m_n[i] = m_pn[i];
                        else          m_run[i] = 0;
                    end
                end else begin
                    m_pos[i]++;
                end
                if (wr && ch == i) begin
                    m_pv[i] = 1; m_pn[i] = dv; m_pen[i] = en_eff;
                end
            end else if (wr && ch == i && en_eff) begin
                m_run[i] = 1; m_n[i] = dv; m_pos[i] = 0;
            end
            // High for the first ceil(N/2) cycles of the period.
            e.dv[i] = m_run[i] && (2 * m_pos[i] < m_n[i]);
            e.tk[i] = m_run[i] && (m_pos[i] == 0);
            e.rn[i] = m_run[i];
            e.pd[i] = m_pv[i];
        end
        e.er = wr && (ch >= NC);
    endtask

    task automatic cyc(input bit wr, input int ch, input int dv, input bit en, input bit sy);
        exp_t e;
        @(negedge clk);
        cfg_if.cfg_wr  = wr;
        cfg_if.cfg_ch  = CW'(ch);
        cfg_if.cfg_div = DW'(dv);
        cfg_if.cfg_en  = en;
`ifdef CLK_DIV_GEN_SYNC_EN
        sync = sy;
        model_step(wr, ch, dv, en, sy, e);
`else
        sync = 1'b0;
        model_step(wr, ch, dv, en, 1'b0, e);
`endif
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_div"},  32'(div_o),  32'h0);
        chk({tag, "_tick"}, 32'(tick_o), 32'h0);
        chk({tag, "_run"},  32'(run_o),  32'h0);
        chk({tag, "_pend"}, 32'(pend_o), 32'h0);
        chk({tag, "_err"},  32'(cfg_if.cfg_err), 32'h0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("div",  32'(div_o),  32'(e.dv));
            chk("tick", 32'(tick_o), 32'(e.tk));
            chk("run",  32'(run_o),  32'(e.rn));
            chk("pend", 32'(pend_o), 32'(e.pd));
            chk("err",  32'(cfg_if.cfg_err), 32'(e.er));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sync  = 1'b0;
        cfg_if.cfg_wr  = 1'b0;
        cfg_if.cfg_ch  = '0;
        cfg_if.cfg_div = '0;
        cfg_if.cfg_en  = 1'b0;
        model_reset();
        #23;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 0, 4, 1, 0);           // even ratio
        idle(11);
        cyc(1, 1, 5, 1, 0);           // odd ratio
        cyc(1, 2, 1, 1, 0);           // N=1
        idle(10);
        cyc(1, 0, 6, 1, 0);           // retune while running
        idle(14);
        cyc(1, 0, 8, 1, 0);
        idle(9);
        cyc(1, 0, 0, 1, 0);           // div=0 disables at wrap
        cyc(1, 0, 0, 0, 0);           // overwrite pending
        idle(16);
        cyc(1, 7, 3, 1, 0);           // illegal channel
        idle(3);
        cyc(1, 3, 5, 0, 0);           // disabled write to idle channel
        idle(3);
        cyc(1, 4, 15, 1, 0);          // max ratio
        idle(20);

        cyc(1, 0, 4, 1, 0);
        idle(1);
        cyc(1, 5, 6, 1, 0);
        idle(3);
        cyc(1, 5, 3, 1, 1);           // sync coincident with a write
        idle(8);
        mid_reset();

        for (int k = 0; k < 3000; k++) begin
            bit wr, en, sy;
            int ch, dv;
            wr = ($urandom_range(7) == 0);
            ch = $urandom_range(7);
            dv = $urandom_range(15);
            en = ($urandom_range(4) != 0);
            sy = ($urandom_range(23) == 0);
            cyc(wr, ch, dv, en, sy);
        end
        mid_reset();
        idle(4);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
